// File: rtl/adc_status_in.sv
// Avalon-MM status input port for the ADC board: synchronizes and de-glitches the
// status pins, latches edges into a write-1-to-clear capture register and raises a maskable irq.
module adc_status_in #(
  parameter int WIDTH      = 8,
  parameter int EDGE_TYPE  = 0,
  parameter int FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_1;
  logic [WIDTH-1:0] sync_2;
  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] filtered_d;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] capture_clr;
  logic             wr_en;
  logic             rd_en;
  logic [31:0]      rd_mux;
  logic             unused_writedata;

  assign unused_writedata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= in_port;
      sync_2 <= sync_1;
    end
  end

  // A bit only follows the synchronizer after it has disagreed for FILTER_LEN consecutive cycles.
  generate
    if (FILTER_LEN == 0) begin : g_no_filter
      assign filtered = sync_2;
    end else begin : g_filter
      localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
      localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] cnt;
        logic          filt_bit;

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            cnt      <= '0;
            filt_bit <= 1'b0;
          end else if (sync_2[i] == filt_bit) begin
            cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            filt_bit <= sync_2[i];
            cnt      <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        assign filtered[i] = filt_bit;
      end
    end
  endgenerate

  always_comb begin
    edges = '0;
    case (EDGE_TYPE)
      0:       edges = filtered & ~filtered_d;
      1:       edges = ~filtered & filtered_d;
      default: edges = filtered ^ filtered_d;
    endcase
  end

  assign wr_en       = chipselect & ~write_n;
  assign rd_en       = chipselect & ~read_n;
  assign capture_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = 32'(filtered);
      2'd2:    rd_mux = 32'(irq_mask);
      2'd3:    rd_mux = 32'(edge_capture);
      default: rd_mux = '0;
    endcase
  end

  // New edges are OR-ed in after the clear so a simultaneous set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filtered_d   <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
      irq          <= 1'b0;
      readdata     <= '0;
    end else begin
      filtered_d   <= filtered;
      edge_capture <= (edge_capture & ~capture_clr) | edges;
      irq          <= |(edge_capture & irq_mask);
      if (wr_en && address == 2'd2) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      if (rd_en) begin
        readdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_adc_status_in.sv
// Scoreboard bench for adc_status_in: a rising-edge instance (u_dut0) and a
// falling-edge instance (u_dut1); expected responses are queued at issue time.
module tb_adc_status_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs0;
  logic        cs1;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic [31:0] rd0;
  logic [31:0] rd1;
  logic        irq0;
  logic        irq1;
  logic        irq_sample;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  adc_status_in #(.WIDTH(8), .EDGE_TYPE(0), .FILTER_LEN(4)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in0), .readdata(rd0), .irq(irq0)
  );

  adc_status_in #(.WIDTH(8), .EDGE_TYPE(1), .FILTER_LEN(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in1), .readdata(rd1), .irq(irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a read strobe or irq sample request on an edge means the DUT has an answer 1 time unit later.
  always @(posedge clk) begin
    if (((cs0 || cs1) && !read_n) || irq_sample) begin
      #1;
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        case (e.kind)
          0:       check(e.name, rd0, e.exp);
          1:       check(e.name, rd1, e.exp);
          default: check(e.name, {31'd0, irq0}, e.exp);
        endcase
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input int dut, input logic [1:0] a, input logic [31:0] exp, input string name);
    sb_q.push_back('{name: name, kind: dut, exp: exp});
    address = a;
    read_n  = 1'b0;
    if (dut == 0) cs0 = 1'b1; else cs1 = 1'b1;
    @(negedge clk);
    cs0    = 1'b0;
    cs1    = 1'b0;
    read_n = 1'b1;
  endtask

  task automatic bus_write(input int dut, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    if (dut == 0) cs0 = 1'b1; else cs1 = 1'b1;
    @(negedge clk);
    cs0       = 1'b0;
    cs1       = 1'b0;
    write_n   = 1'b1;
    writedata = '0;
  endtask

  task automatic check_irq(input logic exp, input string name);
    sb_q.push_back('{name: name, kind: 2, exp: {31'd0, exp}});
    irq_sample = 1'b1;
    @(negedge clk);
    irq_sample = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    cs0        = 1'b0;
    cs1        = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    writedata  = '0;
    in0        = '0;
    in1        = '0;
    irq_sample = 1'b0;

    idle(3);
    check("reset_readdata", rd0, 32'h0);
    check("reset_irq", {31'd0, irq0}, 32'h0);
    reset_n = 1'b1;
    idle(1);
    bus_read(0, 2'd0, 32'h0, "reset_addr0");
    bus_read(0, 2'd2, 32'h0, "reset_mask");
    bus_read(0, 2'd3, 32'h0, "reset_capture");
    check_irq(1'b0, "reset_irq_sb");

    // Bit 0 rises: filtered value appears on edge 6, capture on edge 7.
    in0 = 8'h01;
    idle(5);
    bus_read(0, 2'd0, 32'h00, "filt_edge6");
    bus_read(0, 2'd0, 32'h01, "filt_edge7");
    bus_read(0, 2'd3, 32'h01, "capture_edge8");

    // Two-cycle glitch on bit 1 must be rejected.
    bus_write(0, 2'd3, 32'hFF);
    in0 = 8'h03;
    idle(2);
    in0 = 8'h01;
    idle(12);
    bus_read(0, 2'd0, 32'h01, "glitch_addr0");
    bus_read(0, 2'd3, 32'h00, "glitch_capture");

    // Mask, irq assertion and write-1-to-clear.
    bus_write(0, 2'd2, 32'hFFFFFF01);
    bus_read(0, 2'd2, 32'h01, "mask_upper_ignored");
    check_irq(1'b0, "irq_idle");
    in0 = 8'h00;
    idle(10);
    bus_read(0, 2'd3, 32'h00, "fall_ignored");
    in0 = 8'h01;
    idle(10);
    bus_read(0, 2'd3, 32'h01, "rise_capture");
    check_irq(1'b1, "irq_set");
    bus_write(0, 2'd3, 32'h01);
    check_irq(1'b0, "irq_cleared");
    bus_read(0, 2'd3, 32'h00, "capture_cleared");
    in0 = 8'h05;
    idle(10);
    bus_read(0, 2'd3, 32'h04, "masked_capture");
    check_irq(1'b0, "masked_irq");

    // Clear of bit 3 lands on the same edge that captures its rise: set wins.
    bus_write(0, 2'd3, 32'hFF);
    in0 = 8'h0D;
    idle(6);
    bus_write(0, 2'd3, 32'h08);
    bus_read(0, 2'd3, 32'h08, "set_beats_clear");

    // Falling-edge instance.
    in1 = 8'h04;
    idle(10);
    bus_read(1, 2'd3, 32'h00, "fall_rise_ignored");
    bus_read(1, 2'd0, 32'h04, "fall_addr0");
    in1 = 8'h00;
    idle(10);
    bus_read(1, 2'd3, 32'h04, "fall_capture");
    bus_write(1, 2'd1, 32'hFFFFFFFF);
    bus_read(1, 2'd1, 32'h00, "reserved_addr1");

    // Asynchronous reset with everything set.
    bus_write(0, 2'd3, 32'hFF);
    bus_write(0, 2'd2, 32'hFF);
    in0 = 8'h00;
    idle(10);
    in0 = 8'hFF;
    idle(10);
    bus_read(0, 2'd3, 32'hFF, "all_capture");
    check_irq(1'b1, "all_irq");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_readdata", rd0, 32'h0);
    check("async_irq", {31'd0, irq0}, 32'h0);
    check("async_capture", 32'(u_dut0.edge_capture), 32'h0);
    check("async_mask", 32'(u_dut0.irq_mask), 32'h0);
    in0 = 8'h00;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    bus_read(0, 2'd3, 32'h00, "post_reset_capture");
    bus_read(0, 2'd2, 32'h00, "post_reset_mask");
    check_irq(1'b0, "post_reset_irq");

    idle(2);
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_status_in.md
ADC_STATUS_IN -- requirements
Module: adc_status_in

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of input status bits (1..32).
REQ-002 SHALL have parameter EDGE_TYPE, default 0, edge type: 0 rising, 1 falling, 2 any.
REQ-003 SHALL have parameter FILTER_LEN, default 4, number of stable cycles required before a filtered bit changes; 0 bypasses the filter.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port address  input  2  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port read_n  input  1  active-low read strobe.
REQ-009 SHALL have port write_n  input  1  active-low write strobe.
REQ-010 SHALL have port writedata  input  32  write data.
REQ-011 SHALL have port in_port  input  WIDTH  asynchronous status inputs from ADC board.
REQ-012 SHALL have port readdata  output  32  registered read data.
REQ-013 SHALL have port irq  output  1  level interrupt to CPU.

Function
REQ-014 SHALL pass each in_port bit through a 2-flop synchronizer; sync output is 2 cycles behind the pin.
REQ-015 SHALL, per bit and when FILTER_LEN>0, hold a counter that clears when the sync value equals the filtered value, else increments; at count FILTER_LEN-1 the filtered bit takes the sync value and the counter clears.
REQ-016 SHALL, when FILTER_LEN=0, use the sync value directly as the filtered value.
REQ-017 SHALL keep a one-cycle-delayed copy of the filtered value; edge detect compares current vs delayed per EDGE_TYPE.
REQ-018 SHALL set edge_capture[i] on a detected edge of bit i; the bit stays set until cleared by software.
REQ-019 SHALL map address 0: read = filtered value, zero-extended to 32 bits; writes ignored.
REQ-020 SHALL map address 1: reserved; read 0; writes ignored.
REQ-021 SHALL map address 2: irq_mask[WIDTH-1:0], read/write.
REQ-022 SHALL map address 3: edge_capture; read returns it; write clears each bit whose writedata bit is 1 (write-1-to-clear).
REQ-023 SHALL perform a write when chipselect=1 and write_n=0; register updates on that clock edge.
REQ-024 SHALL register readdata on the edge where chipselect=1 and read_n=0 (read latency 1); readdata holds its value otherwise.
REQ-025 SHALL give priority to set when an edge and a clear hit the same bit in the same cycle; the bit remains 1.
REQ-026 SHALL drive irq registered: irq = OR(edge_capture & irq_mask), updated 1 cycle after either changes.
REQ-027 SHALL ignore writedata bits at and above WIDTH.
REQ-028 SHALL NOT let in_port glitches shorter than FILTER_LEN cycles (after sync) change the filtered value or set edge_capture.

Reset
REQ-029 SHALL, on reset_n=0 asynchronously, clear sync flops, filter counters, filtered and delayed values, irq_mask, edge_capture, readdata and irq to 0.
REQ-030 SHALL treat inputs already high at reset release as rising edges once they pass sync and filter (EDGE_TYPE 0 or 2); reset mid-filter discards the partial count.

Verification
REQ-031 SHALL verify: WIDTH=8, FILTER_LEN=4, in_port 0x00->0x01 held -> addr0 reads 0x01 and edge_capture=0x01 by cycle 2+4+1 after the change.
REQ-032 SHALL verify: in_port[0] pulse 2 cycles wide, FILTER_LEN=4 -> addr0 stays 0x00 and edge_capture stays 0x00.
REQ-033 SHALL verify: irq_mask=0x01, rising edge on bit 0 -> irq=1; write 0x01 to addr3 -> edge_capture=0x00 and irq=0 one cycle later.
REQ-034 SHALL verify: edge on bit 3 in the same cycle as a write of 0x08 to addr3 -> edge_capture[3]=1.
REQ-035 SHALL verify: EDGE_TYPE=1, bit 2 rises then falls -> capture is set only after the fall; write 0xFFFFFFFF to addr1 -> addr1 reads 0.
REQ-036 SHALL verify: reset_n asserted with edge_capture=0xFF and irq=1 -> all registers and irq are 0 immediately, without waiting for a clock.
